// File: rtl/seq_detect_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param_if
//  Description : Control/status bundle for the parametrised serial sequence
//                detector. The master side drives the serial bit stream and
//                the control strobes; the slave side (the detector) returns
//                its FSM state, match flag and match counter.
//  Ports       : en, x1, x1_valid, overlap, pat_load, pat_in, cnt_clr (to detector)
//                y, z1, match_cnt, cnt_sat                          (from detector)
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             x1;
  logic             x1_valid;
  logic             overlap;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic [1:0]       y;
  logic             z1;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, x1, x1_valid, overlap, pat_load, pat_in, cnt_clr,
    input  y, z1, match_cnt, cnt_sat
  );

  modport slave (
    input  en, x1, x1_valid, overlap, pat_load, pat_in, cnt_clr,
    output y, z1, match_cnt, cnt_sat
  );
endinterface
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Moore serial sequence detector with a runtime-loadable
//                PAT_W-bit pattern, overlapping/non-overlapping match modes,
//                a registered one-cycle match flag and a saturating counter.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-low reset
//                bus  - seq_detect_param_if.slave (controls in, status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = 4'b1101
) (
  input  wire logic          clk,
  input  wire logic          rst,
  seq_detect_param_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HUNT = 2'b01,
    HIT  = 2'b10
  } state_t;

  state_t            r_state;
  logic              r_z1;
  logic [PAT_W-1:0]  r_hist;
  logic [PAT_W-1:0]  r_pat;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_cnt;

  logic [PAT_W-1:0]  w_nh;
  logic [FILL_W-1:0] w_nf;
  logic              w_active;
  logic              w_match;

  // Newest bit enters at [0], so the oldest bit lines up with the pattern MSB.
  assign w_nh = {r_hist[PAT_W-2:0], bus.x1};

  // Fill saturates at PAT_W: a full window is required before any compare.
  assign w_nf = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);

  // Bits are only consumed in the two running states; the IDLE->HUNT edge
  // and the unused encoding never sample.
  assign w_active = (r_state == HUNT) || (r_state == HIT);

  assign w_match = w_active && bus.en && !bus.pat_load && bus.x1_valid &&
                   (w_nh == r_pat) && (w_nf == FILL_W'(PAT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_z1    <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= RESET_PAT;
    end else if (!bus.en) begin
      r_state <= IDLE;
      r_z1    <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
    end else if (bus.pat_load) begin
      // The x1 presented with a load is discarded; matching restarts cleanly.
      r_pat   <= bus.pat_in;
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= HUNT;
      r_z1    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= HUNT;
          r_z1    <= 1'b0;
        end
        HUNT, HIT: begin
          if (bus.x1_valid) begin
            r_hist <= w_nh;
            // Non-overlapping mode demands PAT_W fresh bits after a hit.
            r_fill <= (w_match && !bus.overlap) ? '0 : w_nf;
          end
          // z1 is the registered image of the next state being HIT.
          r_state <= w_match ? HIT : HUNT;
          r_z1    <= w_match;
        end
        default: begin
          r_state <= IDLE;
          r_z1    <= 1'b0;
        end
      endcase
    end
  end

  // Counter clear is independent of en; clear coincident with a hit gives 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= w_match ? CNT_W'(1) : '0;
    end else if (w_match && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.y         = r_state;
  assign bus.z1        = r_z1;
  assign bus.match_cnt = r_cnt;
  assign bus.cnt_sat   = &r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. Two detectors
//                (CNT_W=8 and CNT_W=2) see identical stimulus; a behavioural
//                model queues the expected status for every edge and the
//                queue is drained after each edge against both DUTs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

  localparam int PAT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             en, x1, x1_valid, overlap, pat_load, cnt_clr;
  logic [PAT_W-1:0] pat_in;

  seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(8)) bus_a ();
  seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(2)) bus_b ();

  assign bus_a.en = en;             assign bus_b.en = en;
  assign bus_a.x1 = x1;             assign bus_b.x1 = x1;
  assign bus_a.x1_valid = x1_valid; assign bus_b.x1_valid = x1_valid;
  assign bus_a.overlap = overlap;   assign bus_b.overlap = overlap;
  assign bus_a.pat_load = pat_load; assign bus_b.pat_load = pat_load;
  assign bus_a.pat_in = pat_in;     assign bus_b.pat_in = pat_in;
  assign bus_a.cnt_clr = cnt_clr;   assign bus_b.cnt_clr = cnt_clr;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8), .RESET_PAT(4'b1101)) u_dut_a (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_a)
  );

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2), .RESET_PAT(4'b1101)) u_dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] y;
    logic       z1;
    logic [7:0] cnt;
    logic       sat;
    logic [1:0] cnt2;
    logic       sat2;
  } exp_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model: received bits kept as a window queue, oldest first.
  int         m_y;
  bit         m_hq[$];
  logic [3:0] m_pat;
  int         m_cnt;
  int         m_cnt2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: %s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 0;
    m_hq.delete();
    m_pat = 4'b1101;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_edge();
    bit         hit;
    logic [3:0] win;
    hit = 1'b0;
    if (!en) begin
      m_y = 0;
      m_hq.delete();
    end else if (pat_load) begin
      m_pat = pat_in;
      m_hq.delete();
      m_y = 1;
    end else if (m_y == 0) begin
      m_y = 1;
    end else begin
      if (x1_valid) begin
        m_hq.push_back(x1);
        if (m_hq.size() > PAT_W) void'(m_hq.pop_front());
        if (m_hq.size() == PAT_W) begin
          win = '0;
          for (int i = 0; i < PAT_W; i++) win = {win[2:0], m_hq[i]};
          hit = (win == m_pat);
        end
        if (hit && !overlap) m_hq.delete();
      end
      m_y = hit ? 2 : 1;
    end
    if (cnt_clr) begin
      m_cnt  = hit ? 1 : 0;
      m_cnt2 = hit ? 1 : 0;
    end else if (hit) begin
      if (m_cnt  < 255) m_cnt++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.y    = m_y[1:0];
    e.z1   = (m_y == 2);
    e.cnt  = m_cnt[7:0];
    e.sat  = (m_cnt == 255);
    e.cnt2 = m_cnt2[1:0];
    e.sat2 = (m_cnt2 == 3);
    exp_q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("y",    32'(bus_a.y),         32'(e.y));
      check_val("z1",   32'(bus_a.z1),        32'(e.z1));
      check_val("cnt",  32'(bus_a.match_cnt), 32'(e.cnt));
      check_val("sat",  32'(bus_a.cnt_sat),   32'(e.sat));
      check_val("y_b",  32'(bus_b.y),         32'(e.y));
      check_val("z1_b", 32'(bus_b.z1),        32'(e.z1));
      check_val("cnt2", 32'(bus_b.match_cnt), 32'(e.cnt2));
      check_val("sat2", 32'(bus_b.cnt_sat),   32'(e.sat2));
    end
  endtask

  // Called just after a rising edge: drive, predict, take the edge, compare.
  task automatic step(input logic b, input logic v);
    x1       = b;
    x1_valid = v;
    model_edge();
    push_exp();
    @(posedge clk);
    #1;
    pop_compare();
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic bits(input logic [7:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) step(seq[i], 1'b1);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    pop_compare();
  endtask

  task automatic load(input logic [3:0] p);
    pat_load = 1'b1;
    pat_in   = p;
    cnt_clr  = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; x1 = 1'b0; x1_valid = 1'b0;
    overlap = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    push_exp();
    pop_compare();
    rst_n = 1'b1;

    // Default 1101, overlapping: hits after bits 4 and 7.
    phase = "t1";
    en = 1'b1; overlap = 1'b1;
    step(1'b0, 1'b0);
    bits(8'b0110_1101, 7);
    check_val("t1_cnt", 32'(bus_a.match_cnt), 32'd2);

    // 1111 with eight ones, overlapping: five back-to-back hits.
    phase = "t2a";
    load(4'b1111);
    bits(8'hFF, 8);
    check_val("t2a_cnt",  32'(bus_a.match_cnt), 32'd5);
    check_val("t2a_cnt2", 32'(bus_b.match_cnt), 32'd3);
    check_val("t2a_sat2", 32'(bus_b.cnt_sat),   32'd1);

    // Clear coincident with a hit leaves the counter at 1.
    phase = "t5";
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    check_val("t5_cnt",  32'(bus_a.match_cnt), 32'd1);
    check_val("t5_cnt2", 32'(bus_b.match_cnt), 32'd1);

    // Reset from HIT, then non-overlapping 1111.
    phase = "t2b";
    async_reset();
    rst_n = 1'b1; overlap = 1'b0;
    step(1'b0, 1'b0);
    load(4'b1111);
    bits(8'hFF, 8);
    check_val("t2b_cnt", 32'(bus_a.match_cnt), 32'd2);

    // Valid gaps with toggling x1 do not disturb the partial match.
    phase = "t3";
    overlap = 1'b1;
    load(4'b1101);
    for (int i = 3; i >= 0; i--) begin
      step(4'b1101 >> i, 1'b1);
      for (int g = 0; g < 3; g++) step(1'($urandom_range(0, 1)), 1'b0);
    end
    check_val("t3_cnt", 32'(bus_a.match_cnt), 32'd1);

    // Load mid-stream discards the old history and the coincident bit.
    phase = "t4";
    load(4'b1101);
    bits(8'b110, 3);
    pat_load = 1'b1; pat_in = 4'b0101;
    step(1'b1, 1'b1);
    bits(8'b10101, 5);
    check_val("t4_cnt", 32'(bus_a.match_cnt), 32'd1);
    check_val("t4_z1",  32'(bus_a.z1),        32'd1);

    // Async reset restores 1101; en=0 drops partial history.
    phase = "t6";
    async_reset();
    check_val("t6_y", 32'(bus_a.y), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check_val("t6_hunt", 32'(bus_a.y), 32'd1);
    bits(8'b11, 2);
    en = 1'b0;
    step(1'b0, 1'b1);
    en = 1'b1;
    step(1'b1, 1'b1);
    bits(8'b01, 2);
    bits(8'b1101, 4);
    check_val("t6_cnt", 32'(bus_a.match_cnt), 32'd1);

    // Random burst with valid gaps and overlap changes.
    phase = "rand";
    pat_load = 1'b1; pat_in = 4'b1011;
    step(1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) overlap = ~overlap;
      if ($urandom_range(0, 15) == 0) cnt_clr = 1'b1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised Moore serial sequence detector, successor to the fixed 5-state "1101" detector. Serial bits arrive on x1 with a valid strobe and are compared against a runtime-loadable pattern of PAT_W bits. Overlapping and non-overlapping match modes are selectable. The block provides a registered one-cycle match pulse and a saturating match counter for status readout.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16
CNT_W, 8, match counter width; legal range 1..16
RESET_PAT, 4'b1101, pattern loaded at reset; PAT_W bits wide, MSB is the first bit received

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  detector enable; 0 forces IDLE
x1  input  1  serial data bit
x1_valid  input  1  x1 is sampled only on edges where this is 1
overlap  input  1  1 = overlapping matches, 0 = non-overlapping
pat_load  input  1  load pat_in into the pattern register
pat_in  input  PAT_W  new pattern; MSB is the first bit received
cnt_clr  input  1  clear match_cnt
y  output  2  FSM state: IDLE=00, HUNT=01, HIT=10; 11 unused, next edge goes to IDLE
z1  output  1  Moore match flag, equal to (y==HIT); registered, no clock gating
match_cnt  output  CNT_W  saturating count of matches
cnt_sat  output  1  match_cnt is all ones

Behaviour:
- Reset (rst=0, asynchronous): y=IDLE, z1=0, hist=0, fill=0, pat=RESET_PAT, match_cnt=0, cnt_sat=0.
- Internal state:
  - hist[PAT_W-1:0]: shift register, newest bit at [0]. nh={hist[PAT_W-2:0],x1}.
  - fill: counts valid bits received, saturates at PAT_W. nf=min(fill+1,PAT_W).
- Match condition, evaluated per edge: y!=IDLE & en & !pat_load & x1_valid & nh==pat & nf==PAT_W.
- Priority per edge, highest first: rst, then en=0, then pat_load, then bit processing. cnt_clr is independent of en.
- en=0: next y=IDLE; hist and fill cleared; no bit is shifted and no match is counted.
- pat_load=1 (with en=1): pat<=pat_in; hist and fill cleared; next y=HUNT; x1 on that edge is discarded.
- Bit processing, only when x1_valid=1:
  - hist<=nh.
  - fill<=nf, except on a match with overlap=0, where fill<=0 so the next match needs PAT_W fresh bits.
- FSM transitions:
  - IDLE: en=1 -> HUNT. No bit is sampled on the IDLE->HUNT edge.
  - HUNT: match -> HIT; otherwise stay in HUNT.
  - HIT: match -> HIT, giving back-to-back pulses (overlap mode only). Otherwise -> HUNT, including when x1_valid=0.
- Latency: z1 rises in the cycle after the edge that samples the final pattern bit. z1 is high for exactly one cycle per match.
- x1_valid=0 gaps do not break partial matches: hist and fill hold.
- Counter:
  - On a match, match_cnt increments, saturating at 2^CNT_W-1.
  - cnt_clr alone sets match_cnt to 0.
  - cnt_clr together with a match sets match_cnt to 1.
  - cnt_sat is combinational from match_cnt.
- The overlap input may change at any time and takes effect on the next match evaluation.
- Default parameters reproduce the previous detector's 1101 overlapping sequence. The former clk-gated z1 is replaced by a registered level.

Test Plan:
1. Defaults, en=1, overlap=1, valid bits 1,1,0,1,1,0,1 -> z1=1 for one cycle after bit 4 and after bit 7; match_cnt=2; y returns to 01 between the two hits.
2. Load pat_in=4'b1111, eight consecutive valid 1s:
   - overlap=1 -> z1 high for 5 consecutive cycles (after bits 4..8), y held at 10, match_cnt=5.
   - Repeat after reset with overlap=0 -> pulses after bits 4 and 8 only, match_cnt=2.
3. Defaults, bits 1,1,0,1 with x1_valid=0 for 3 cycles between each bit -> exactly one z1 pulse, one cycle after the edge sampling the last 1; x1 toggling during the gaps is ignored.
4. After valid bits 1,1,0, assert pat_load with pat_in=4'b0101 and x1=1 -> no match on that edge; following bits 1 then 0,1,0,1 -> one match after the final 1, with no false hit from the pre-load history.
5. CNT_W=2, four matches -> match_cnt=3 and cnt_sat=1 after the 3rd match, still 3 after the 4th; then cnt_clr coincident with a match -> match_cnt=1.
6. Drop rst between edges while y=HIT -> z1=0, y=00, match_cnt=0 immediately, pat=1101. Deassert rst with en=1 -> y=01 one edge later; en=0 mid-pattern -> y=00 and partial history discarded.
